traffic_light_controller: RTL and testbench

TRAFFIC_LIGHT_CONTROLLER -- requirements
Module: traffic_light_controller

---
 rtl/traffic_light_controller.sv | 155 +++++++++++++++
 tb/tb_traffic_light_controller.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_controller.sv
// traffic_light_controller
//
// Two-way intersection controller. A phase timer counts up from 0 in every
// state and the FSM advances when it reaches the state's duration minus one,
// so each state lasts exactly its configured number of cycles.
//
// Build option:
//   TLC_ALL_RED_EN  - when defined, an all-red clearance phase follows each
//                     yellow (ALLRED_A after north yellow, ALLRED_B after east
//                     yellow). When undefined, the all-red encodings are
//                     treated as illegal and ALLRED_CYCLES has no effect.
//
// Parameters:
//   GREEN_CYCLES   cycles per green phase   (1 .. 2^TIMER_W-1)
//   YELLOW_CYCLES  cycles per yellow phase  (1 .. 2^TIMER_W-1)
//   ALLRED_CYCLES  cycles per all-red phase (TLC_ALL_RED_EN only)
//   TIMER_W        phase timer width
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   north_light  north lamp, one-hot {red,yellow,green}
//   east_light   east lamp, same encoding
//
// state     | meaning
// ----------+---------------------------------------------
// NS_GREEN  | north green, east red
// NS_YELLOW | north yellow, east red
// EW_GREEN  | east green, north red
// EW_YELLOW | east yellow, north red
// ALLRED_A  | both red, clearing north -> east
// ALLRED_B  | both red, clearing east -> north
// 110/111   | illegal: both red, recover to NS_GREEN

module traffic_light_controller #(
  parameter int GREEN_CYCLES  = 10,
  parameter int YELLOW_CYCLES = 3,
  parameter int ALLRED_CYCLES = 2,
  parameter int TIMER_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  output logic [2:0] north_light,
  output logic [2:0] east_light
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'b000,
    NS_YELLOW = 3'b001,
    EW_GREEN  = 3'b010,
    EW_YELLOW = 3'b011,
    ALLRED_A  = 3'b100,
    ALLRED_B  = 3'b101
  } state_t;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  localparam logic [TIMER_W-1:0] DUR_G = TIMER_W'(GREEN_CYCLES);
  localparam logic [TIMER_W-1:0] DUR_Y = TIMER_W'(YELLOW_CYCLES);
  localparam logic [TIMER_W-1:0] DUR_A = TIMER_W'(ALLRED_CYCLES);

  state_t             state;
  logic [TIMER_W-1:0] timer;

  state_t             next_state;
  logic [TIMER_W-1:0] dur;
  logic               legal;

  // Duration and successor of the current state. An illegal state has no
  // duration of its own; it leaves on the very next edge.
  always_comb begin
    next_state = NS_GREEN;
    dur        = DUR_G;
    legal      = 1'b1;
    case (state)
      NS_GREEN: begin
        dur        = DUR_G;
        next_state = NS_YELLOW;
      end
      NS_YELLOW: begin
        dur        = DUR_Y;
`ifdef TLC_ALL_RED_EN
        next_state = ALLRED_A;
`else
        next_state = EW_GREEN;
`endif
      end
      EW_GREEN: begin
        dur        = DUR_G;
        next_state = EW_YELLOW;
      end
      EW_YELLOW: begin
        dur        = DUR_Y;
`ifdef TLC_ALL_RED_EN
        next_state = ALLRED_B;
`else
        next_state = NS_GREEN;
`endif
      end
      ALLRED_A: begin
        dur        = DUR_A;
`ifdef TLC_ALL_RED_EN
        next_state = EW_GREEN;
`else
        legal      = 1'b0;
        next_state = NS_GREEN;
`endif
      end
      ALLRED_B: begin
        dur        = DUR_A;
        next_state = NS_GREEN;
`ifndef TLC_ALL_RED_EN
        legal      = 1'b0;
`endif
      end
      default: begin
        legal      = 1'b0;
        next_state = NS_GREEN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= NS_GREEN;
      timer <= '0;
    end else if (!legal || (timer == dur - TIMER_W'(1))) begin
      state <= next_state;
      timer <= '0;
    end else begin
      timer <= timer + TIMER_W'(1);
    end
  end

  // Lamps decode straight from state so an asynchronous reset shows on the
  // outputs without waiting for a clock edge. Anything not explicitly a
  // go/caution state shows red both ways.
  always_comb begin
    north_light = LAMP_RED;
    east_light  = LAMP_RED;
    case (state)
      NS_GREEN:  north_light = LAMP_GREEN;
      NS_YELLOW: north_light = LAMP_YELLOW;
      EW_GREEN:  east_light  = LAMP_GREEN;
      EW_YELLOW: east_light  = LAMP_YELLOW;
      default: begin
        north_light = LAMP_RED;
        east_light  = LAMP_RED;
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_light_controller.sv
// Testbench for traffic_light_controller. Two instances share clock and
// reset: one with default timing, one with 1-cycle green and yellow. The
// reference model derives lamps, state and timer from the number of running
// edges since reset using the phase table and plain modular arithmetic.
module tb_traffic_light_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] n0, e0, n1, e1;

  traffic_light_controller dut0 (
    .clk(clk), .reset(reset), .north_light(n0), .east_light(e0)
  );

  traffic_light_controller #(
    .GREEN_CYCLES(1), .YELLOW_CYCLES(1)
  ) dut1 (
    .clk(clk), .reset(reset), .north_light(n1), .east_light(e1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] n0, e0, s0;
    int         t0;
    logic [2:0] n1, e1, s1;
    int         t1;
  } exp_t;

  exp_t q[$];
  exp_t mon_x;
  int   compared   = 0;
  int   mismatched = 0;
  int   pos        = 0;  // running edges since reset was last low

  task automatic chk3(input string name, input logic [2:0] act, input logic [2:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  task automatic chkint(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_safe(input string name, input logic [2:0] n, input logic [2:0] e);
    compared++;
    if (!($onehot(n) && $onehot(e) && (n == 3'b100 || e == 3'b100))) begin
      mismatched++;
      $display("FAIL %s: got north=%b east=%b expected one-hot lamps with one red", name, n, e);
    end
  endtask

  // Phase table walked with the position modulo the full cycle length.
  function automatic void model(input int p_in, input int g, input int y, input int a,
                                output logic [2:0] st, output int tm,
                                output logic [2:0] nl, output logic [2:0] el);
    int         d[6];
    logic [2:0] code[6];
    logic [2:0] nt[6];
    logic [2:0] et[6];
    int         nph, period, p;
    bit         found;
`ifdef TLC_ALL_RED_EN
    nph = 6;
    d[0] = g; d[1] = y; d[2] = a; d[3] = g; d[4] = y; d[5] = a;
    code[0] = 3'b000; code[1] = 3'b001; code[2] = 3'b100;
    code[3] = 3'b010; code[4] = 3'b011; code[5] = 3'b101;
    nt[0] = 3'b001; nt[1] = 3'b010; nt[2] = 3'b100; nt[3] = 3'b100; nt[4] = 3'b100; nt[5] = 3'b100;
    et[0] = 3'b100; et[1] = 3'b100; et[2] = 3'b100; et[3] = 3'b001; et[4] = 3'b010; et[5] = 3'b100;
`else
    nph = 4;
    d[0] = g; d[1] = y; d[2] = g; d[3] = y; d[4] = 0; d[5] = 0;
    code[0] = 3'b000; code[1] = 3'b001; code[2] = 3'b010; code[3] = 3'b011;
    code[4] = 3'b000; code[5] = 3'b000;
    nt[0] = 3'b001; nt[1] = 3'b010; nt[2] = 3'b100; nt[3] = 3'b100; nt[4] = 3'b100; nt[5] = 3'b100;
    et[0] = 3'b100; et[1] = 3'b100; et[2] = 3'b001; et[3] = 3'b010; et[4] = 3'b100; et[5] = 3'b100;
`endif
    period = 0;
    for (int i = 0; i < nph; i++) period += d[i];
    p     = p_in % period;
    found = 1'b0;
    st = 3'b000; tm = 0; nl = 3'b001; el = 3'b100;
    for (int i = 0; i < nph; i++) begin
      if (!found) begin
        if (p < d[i]) begin
          found = 1'b1;
          st = code[i]; tm = p; nl = nt[i]; el = et[i];
        end else begin
          p -= d[i];
        end
      end
    end
  endfunction

  function automatic exp_t expect_at(input int p);
    exp_t x;
    model(p, 10, 3, 2, x.s0, x.t0, x.n0, x.e0);
    model(p, 1, 1, 2, x.s1, x.t1, x.n1, x.e1);
    return x;
  endfunction

  // One clock: advance the model if reset was high at this edge, then drive
  // reset for the coming cycle and queue the response expected for it.
  task automatic step(input logic rst_next);
    @(posedge clk);
    if (reset) pos++;
    #1;
    reset = rst_next;
    if (!rst_next) pos = 0;
    q.push_back(expect_at(pos));
  endtask

  // Assert reset mid-cycle and check the lamps respond before the next edge.
  task automatic step_async();
    exp_t ex;
    @(posedge clk);
    if (reset) pos++;
    #1;
    ex = expect_at(pos);
    chk3("pre_reset_north", n0, ex.n0);
    chk3("pre_reset_east", e0, ex.e0);
    reset = 1'b0;
    #1;
    chk3("async_reset_north", n0, 3'b001);
    chk3("async_reset_east", e0, 3'b100);
    chk3("async_reset_state", dut0.state, 3'b000);
    chkint("async_reset_timer", int'(dut0.timer), 0);
    pos = 0;
    q.push_back(expect_at(pos));
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_x = q.pop_front();
      chk3("north0", n0, mon_x.n0);
      chk3("east0", e0, mon_x.e0);
      chk3("state0", dut0.state, mon_x.s0);
      chkint("timer0", int'(dut0.timer), mon_x.t0);
      chk3("north1", n1, mon_x.n1);
      chk3("east1", e1, mon_x.e1);
      chk3("state1", dut1.state, mon_x.s1);
      chkint("timer1", int'(dut1.timer), mon_x.t1);
    end
    chk_safe("safety0", n0, e0);
    chk_safe("safety1", n1, e1);
  end

  initial begin
    logic [2:0] st;
    int         tm;
    logic [2:0] nl, el;
    bit         hit;
    int         run;

    reset = 1'b0;
    #1;
    chk3("reset_north", n0, 3'b001);
    chk3("reset_east", e0, 3'b100);
    chk3("reset_state", dut0.state, 3'b000);
    chkint("reset_timer", int'(dut0.timer), 0);

    // One cycle in reset, release, then several full periods.
    step(1'b0);
    step(1'b1);
    repeat (70) step(1'b1);

    // Reset in the middle of EW_GREEN with timer=5.
    hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      model(pos + 1, 10, 3, 2, st, tm, nl, el);
      if (st == 3'b010 && tm == 5) hit = 1'b1;
      else step(1'b1);
    end
    compared++;
    if (!hit) begin
      mismatched++;
      $display("FAIL find_ew_green_t5: got no hit expected hit within 100 cycles");
    end
    step_async();
    step(1'b0);
    step(1'b1);
    repeat (40) step(1'b1);

    // Randomised run lengths and reset pulses.
    for (int seg = 0; seg < 30; seg++) begin
      run = $urandom_range(5, 70);
      repeat (run) step(1'b1);
      if ($urandom_range(0, 1) == 1) step_async();
      else step(1'b0);
      repeat ($urandom_range(0, 2)) step(1'b0);
      step(1'b1);
    end
    repeat (30) step(1'b1);

    @(negedge clk);
    #1;
    chkint("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
